pc_exc_sequencer: RTL and testbench
===================================

Name: pc_exc_sequencer

Overview:
Parametrised program-counter and exception sequencer for the simplified MIPS system. It replaces the inline PC register, PC+1/branch/jump adders, and the combinational EPC capture. It adds features the current core lacks: PC load from switches, a trap vector, return-from-exception, a double-fault halt state, a single-step enable and a saturating exception counter. It sits between the control/ALU/Exception_Handle outputs and the IMEM address.

Parameters:
PC_W, 8, width of PC, EPC, offsets and vectors (word-addressed IMEM, no <<2).
RESET_PC, 0, PC value after reset.
EXC_VECTOR, 'hF0, handler entry address (PC_W bits).
NUM_CAUSES, 4, width of exception cause vector.

Ports:
SYS_clk  in  1  system clock, rising edge.
SYS_rst  in  1  asynchronous, active-low reset.
step_en  in  1  PC/state advance enable (1 = run; pulse = single step).
load  in  1  asynchronous PC-load button/switch (level).
load_val  in  PC_W  value loaded into PC on load.
branch  in  1  branch instruction decoded.
zero  in  1  ALU zero status.
branch_off  in  PC_W  sign-extended immediate, truncated to PC_W.
jump  in  1  jump instruction decoded.
jump_off  in  PC_W  jump immediate, truncated to PC_W.
exc_req  in  NUM_CAUSES  exception causes (overflow, invalid addr, div0, write-to-$0).
eret  in  1  return-from-exception instruction.
pc  out  PC_W  current PC to IMEM.
epc  out  PC_W  PC of the faulting instruction.
cause  out  NUM_CAUSES  latched exc_req of the last accepted exception.
exc_flag  out  1  1 while in HANDLER or HALT.
state  out  2  00 RUN, 01 HANDLER, 10 HALT.
wb_kill  out  1  combinational |exc_req; gates RegWrite/MemWrite/MemRead/Mem2Reg.
exc_count  out  8  saturating count of accepted exceptions.

Behaviour:
- Reset (async, SYS_rst=0): pc=RESET_PC, epc=0, cause=0, state=RUN, exc_flag=0, exc_count=0, load synchroniser flops=0.
- load path: 3-flop synchroniser (s1,s2,s3). load_pulse = s2 & ~s3.
  - pc=load_val becomes visible after the 3rd SYS_clk edge following the rise of load.
  - Acts regardless of step_en and state. Forces state=RUN, exc_flag=0, cause=0. epc and exc_count are kept.
  - Holding load high loads only once.
- All other updates occur only on edges with step_en=1. When step_en=0, all registers hold, except the synchroniser and load_pulse.
- Update priority, highest first: reset > load_pulse > exception > eret > jump > branch-taken > sequential.
- RUN:
  - |exc_req: epc<=pc, cause<=exc_req, pc<=EXC_VECTOR, state<=HANDLER, exc_count+=1 (saturates at 255).
  - else eret: ignored, pc<=pc+1.
  - else jump: pc<=pc+1+jump_off.
  - else branch&zero: pc<=pc+1+branch_off.
  - else pc<=pc+1.
- HANDLER:
  - |exc_req (double fault): state<=HALT, cause<=exc_req. epc and pc are unchanged. exc_count+=1 (saturating).
  - else eret: pc<=epc+1, state<=RUN, cause unchanged.
  - else jump/branch/sequential as in RUN.
- HALT: pc frozen. Ignores all inputs except load_pulse and reset. wb_kill is forced to 1.
- exc_flag = (state!=RUN), registered.
- Arithmetic: all PC sums are modulo 2^PC_W.
  - pc = 2^PC_W−1 sequential → 0.
  - A negative offset wraps below 0 (pc=0, branch_off=all-ones → pc=0).
- Simultaneous events:
  - exc_req with jump/branch/eret: the exception wins and the instruction's write-back is killed.
  - load_pulse with exc_req: the load wins and no exception is counted.
- Reset asserted mid-operation clears everything immediately, including a pending load synchroniser state.

Optional Feature:
Macro PCSEQ_TRACE_EN.
- Defined: adds ports trace_sel in 2 and trace_pc out PC_W.
  - 4-entry circular buffer written with pc on every accepted exception, including double faults.
  - Write pointer wraps 3→0 and is reset to 0. Entries are reset to 0.
  - trace_pc = entry[(wptr−1−trace_sel) mod 4], combinational (trace_sel=0 is the newest entry).
- Undefined: the ports are absent and no buffer storage is synthesised. All other behaviour is identical.

Test Plan:
- Reset, step_en=1, no events for 5 edges → pc 0,1,2,3,4,5; state=00; exc_count=0.
- PC_W=8, pc=10, branch=1, zero=1, branch_off=8'hFC → next pc=7; with zero=0 → next pc=11; pc=8'hFF sequential → 8'h00.
- pc=0x20, exc_req=4'b0001 with jump=1 → pc=0xF0, epc=0x20, cause=0001, exc_flag=1, wb_kill=1 that cycle, exc_count=1. Then eret → pc=0x21, exc_flag=0.
- In HANDLER, exc_req=4'b0100 → state=HALT, pc held at its value for 10 edges despite jump/eret. Then load with load_val=0x40 → pc=0x40 three edges after load rises, state=RUN.
- step_en=0 for 4 edges with load held high → pc holds until load_pulse, then equals load_val. load held high 20 edges → loaded once only. SYS_rst asserted mid-sequence → all outputs return to reset values immediately.
- With PCSEQ_TRACE_EN: 5 exceptions at pcs 1,2,3,4,5 → trace_sel 0..3 returns 5,4,3,2. exc_count reaches 255 after 300 exceptions and stays there.

Source files
------------

// File: rtl/pc_exc_sequencer.sv
// PC/exception sequencer: 1-cycle registered PC/EPC/cause/state; step_en=0 freezes all but the load synchroniser.
// Optional PCSEQ_TRACE_EN adds a 4-entry trace of exception PCs (trace_sel/trace_pc).
module pc_exc_sequencer #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] EXC_VECTOR = 'hF0,
  parameter int              NUM_CAUSES = 4
) (
  input  logic                  SYS_clk,
  input  logic                  SYS_rst,
  input  logic                  step_en,
  input  logic                  load,
  input  logic [PC_W-1:0]       load_val,
  input  logic                  branch,
  input  logic                  zero,
  input  logic [PC_W-1:0]       branch_off,
  input  logic                  jump,
  input  logic [PC_W-1:0]       jump_off,
  input  logic [NUM_CAUSES-1:0] exc_req,
  input  logic                  eret,
  output logic [PC_W-1:0]       pc,
  output logic [PC_W-1:0]       epc,
  output logic [NUM_CAUSES-1:0] cause,
  output logic                  exc_flag,
  output logic [1:0]            state,
  output logic                  wb_kill,
`ifdef PCSEQ_TRACE_EN
  input  logic [1:0]            trace_sel,
  output logic [PC_W-1:0]       trace_pc,
`endif
  output logic [7:0]            exc_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HANDLER = 2'b01,
    ST_HALT    = 2'b10
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_load_sync;
  logic [PC_W-1:0]       r_pc, r_epc;
  logic [NUM_CAUSES-1:0] r_cause;
  logic                  r_exc_flag;
  logic [7:0]            r_exc_count;

  logic                  w_load_pulse;
  logic                  w_exc_any;
  logic                  w_exc_acc;
  logic [PC_W-1:0]       w_pc_seq, w_pc_jump, w_pc_br, w_pc_flow, w_epc_ret;
  logic [PC_W-1:0]       w_pc_nxt, w_epc_nxt;
  logic [NUM_CAUSES-1:0] w_cause_nxt;
  logic [7:0]            w_count_nxt;

  assign w_load_pulse = r_load_sync[1] & ~r_load_sync[2];
  assign w_exc_any    = |exc_req;

  // All sums wrap modulo 2^PC_W; offsets are already sign-extended/truncated.
  assign w_pc_seq  = r_pc + PC_W'(1);
  assign w_pc_jump = w_pc_seq + jump_off;
  assign w_pc_br   = w_pc_seq + branch_off;
  assign w_epc_ret = r_epc + PC_W'(1);
  assign w_pc_flow = jump ? w_pc_jump : ((branch & zero) ? w_pc_br : w_pc_seq);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_cause_nxt = r_cause;
    w_exc_acc   = 1'b0;
    if (w_load_pulse) begin
      w_pc_nxt    = load_val;
      w_state_nxt = ST_RUN;
      w_cause_nxt = '0;
    end else if (step_en) begin
      case (r_state)
        ST_RUN: begin
          if (w_exc_any) begin
            w_epc_nxt   = r_pc;
            w_cause_nxt = exc_req;
            w_pc_nxt    = EXC_VECTOR;
            w_state_nxt = ST_HANDLER;
            w_exc_acc   = 1'b1;
          end else if (eret) begin
            w_pc_nxt = w_pc_seq;
          end else begin
            w_pc_nxt = w_pc_flow;
          end
        end
        ST_HANDLER: begin
          // Double fault: keep pc/epc so the halted state shows where it died.
          if (w_exc_any) begin
            w_cause_nxt = exc_req;
            w_state_nxt = ST_HALT;
            w_exc_acc   = 1'b1;
          end else if (eret) begin
            w_pc_nxt    = w_epc_ret;
            w_state_nxt = ST_RUN;
          end else begin
            w_pc_nxt = w_pc_flow;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  assign w_count_nxt = (w_exc_acc && (r_exc_count != 8'hFF)) ? r_exc_count + 8'd1 : r_exc_count;

  always_ff @(posedge SYS_clk or negedge SYS_rst) begin
    if (!SYS_rst) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge SYS_clk or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_load_sync <= 3'b000;
      r_pc        <= RESET_PC;
      r_epc       <= '0;
      r_cause     <= '0;
      r_exc_flag  <= 1'b0;
      r_exc_count <= 8'd0;
    end else begin
      r_load_sync <= {r_load_sync[1:0], load};
      r_pc        <= w_pc_nxt;
      r_epc       <= w_epc_nxt;
      r_cause     <= w_cause_nxt;
      r_exc_flag  <= (w_state_nxt != ST_RUN);
      r_exc_count <= w_count_nxt;
    end
  end

`ifdef PCSEQ_TRACE_EN
  logic [PC_W-1:0] r_trace [4];
  logic [1:0]      r_trace_wptr;
  logic [1:0]      w_trace_idx;

  always_ff @(posedge SYS_clk or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_trace_wptr <= 2'd0;
      for (int i = 0; i < 4; i++) r_trace[i] <= '0;
    end else if (w_exc_acc) begin
      r_trace[r_trace_wptr] <= r_pc;
      r_trace_wptr          <= r_trace_wptr + 2'd1;
    end
  end

  // trace_sel=0 selects the most recently written entry.
  assign w_trace_idx = r_trace_wptr - 2'd1 - trace_sel;
  assign trace_pc    = r_trace[w_trace_idx];
`endif

  assign pc        = r_pc;
  assign epc       = r_epc;
  assign cause     = r_cause;
  assign exc_flag  = r_exc_flag;
  assign state     = r_state;
  assign exc_count = r_exc_count;
  assign wb_kill   = w_exc_any | (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_exc_sequencer.sv
// Directed bench for pc_exc_sequencer: PC flow, exceptions, halt, load sync, reset, saturation.
module tb_pc_exc_sequencer;
  logic       SYS_clk = 1'b0;
  logic       SYS_rst;
  logic       step_en, load, branch, zero, jump, eret;
  logic [7:0] load_val, branch_off, jump_off;
  logic [3:0] exc_req;
  logic [7:0] pc, epc, exc_count;
  logic [3:0] cause;
  logic       exc_flag, wb_kill;
  logic [1:0] state;
`ifdef PCSEQ_TRACE_EN
  logic [1:0] trace_sel;
  logic [7:0] trace_pc;
`endif

  int n_chk = 0;
  int n_err = 0;

  pc_exc_sequencer dut (
    .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .step_en(step_en), .load(load),
    .load_val(load_val), .branch(branch), .zero(zero), .branch_off(branch_off),
    .jump(jump), .jump_off(jump_off), .exc_req(exc_req), .eret(eret),
    .pc(pc), .epc(epc), .cause(cause), .exc_flag(exc_flag), .state(state),
    .wb_kill(wb_kill),
`ifdef PCSEQ_TRACE_EN
    .trace_sel(trace_sel), .trace_pc(trace_pc),
`endif
    .exc_count(exc_count)
  );

  always #5 SYS_clk = ~SYS_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", pc, 8'h00);
    chk("rst_epc", epc, 8'h00);
    chk("rst_cause", cause, 4'h0);
    chk("rst_state", state, 2'b00);
    chk("rst_flag", exc_flag, 1'b0);
    chk("rst_count", exc_count, 8'd0);
    chk("rst_wbkill", wb_kill, 1'b0);
  endtask

  initial begin
    SYS_rst = 1'b0; step_en = 1'b1; load = 1'b0; load_val = 8'h00;
    branch = 1'b0; zero = 1'b0; branch_off = 8'h00; jump = 1'b0; jump_off = 8'h00;
    exc_req = 4'h0; eret = 1'b0;
`ifdef PCSEQ_TRACE_EN
    trace_sel = 2'd0;
`endif
    tick();
    chk_reset_vals();
    SYS_rst = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", pc, i);
    end
    chk("seq_state", state, 2'b00);
    chk("seq_count", exc_count, 8'd0);

    // 5+1+4 = 10; 10+1-4 = 7; 7+1+2 = 10; not taken -> 11; 11+1+0xF3 = 0xFF; wrap -> 0
    jump = 1'b1; jump_off = 8'h04; tick(); chk("jump_pc", pc, 8'h0A);
    jump = 1'b0; branch = 1'b1; zero = 1'b1; branch_off = 8'hFC; tick(); chk("br_neg", pc, 8'h07);
    branch = 1'b0; jump = 1'b1; jump_off = 8'h02; tick(); chk("jump_pc2", pc, 8'h0A);
    jump = 1'b0; branch = 1'b1; zero = 1'b0; tick(); chk("br_not_taken", pc, 8'h0B);
    branch = 1'b0; jump = 1'b1; jump_off = 8'hF3; tick(); chk("jump_to_ff", pc, 8'hFF);
    jump = 1'b0; tick(); chk("seq_wrap", pc, 8'h00);
    branch = 1'b1; zero = 1'b1; branch_off = 8'hFF; tick(); chk("br_wrap0", pc, 8'h00);
    branch = 1'b0; zero = 1'b0; jump = 1'b1; jump_off = 8'h1F; tick(); chk("jump_20", pc, 8'h20);

    // Exception with a simultaneous jump
    jump_off = 8'h05; exc_req = 4'b0001; #1;
    chk("wbkill_exc", wb_kill, 1'b1);
    tick();
    chk("exc_pc", pc, 8'hF0);
    chk("exc_epc", epc, 8'h20);
    chk("exc_cause", cause, 4'b0001);
    chk("exc_flag", exc_flag, 1'b1);
    chk("exc_state", state, 2'b01);
    chk("exc_count1", exc_count, 8'd1);
    exc_req = 4'h0; jump = 1'b0; eret = 1'b1; #1;
    chk("wbkill_clr", wb_kill, 1'b0);
    tick();
    chk("eret_pc", pc, 8'h21);
    chk("eret_flag", exc_flag, 1'b0);
    chk("eret_state", state, 2'b00);
    chk("eret_cause", cause, 4'b0001);

    // Enter handler, step once, then double fault
    eret = 1'b0; exc_req = 4'b0001; tick();
    chk("exc2_pc", pc, 8'hF0); chk("exc2_epc", epc, 8'h21); chk("exc2_count", exc_count, 8'd2);
    exc_req = 4'h0; tick(); chk("hdl_seq", pc, 8'hF1);
    exc_req = 4'b0100; tick();
    chk("halt_state", state, 2'b10);
    chk("halt_cause", cause, 4'b0100);
    chk("halt_pc", pc, 8'hF1);
    chk("halt_epc", epc, 8'h21);
    chk("halt_count", exc_count, 8'd3);
    chk("halt_flag", exc_flag, 1'b1);
    exc_req = 4'h0; #1;
    chk("halt_wbkill", wb_kill, 1'b1);
    jump = 1'b1; eret = 1'b1; jump_off = 8'h10;
    for (int i = 0; i < 10; i++) begin
      exc_req = (i % 2 == 1) ? 4'b0010 : 4'b0000;
      tick();
      chk("halt_hold_pc", pc, 8'hF1);
    end
    chk("halt_hold_count", exc_count, 8'd3);
    chk("halt_hold_state", state, 2'b10);

    // Load out of HALT: visible after 3rd edge
    jump = 1'b0; eret = 1'b0; exc_req = 4'h0;
    load_val = 8'h40; load = 1'b1;
    tick(); chk("load_e1", pc, 8'hF1);
    tick(); chk("load_e2", pc, 8'hF1);
    tick();
    chk("load_pc", pc, 8'h40);
    chk("load_state", state, 2'b00);
    chk("load_flag", exc_flag, 1'b0);
    chk("load_cause", cause, 4'h0);
    chk("load_epc_kept", epc, 8'h21);
    chk("load_count_kept", exc_count, 8'd3);
    load = 1'b0; tick(); chk("post_load", pc, 8'h41);

    // Load while stepping is disabled, then held high for 20 edges
    step_en = 1'b0; load_val = 8'h77; load = 1'b1;
    tick(); chk("stall_e1", pc, 8'h41);
    tick(); chk("stall_e2", pc, 8'h41);
    tick(); chk("stall_load", pc, 8'h77);
    tick(); chk("stall_hold", pc, 8'h77);
    step_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("load_once", pc, 8'h8B);

    // Load pulse coincides with an exception: load wins
    load = 1'b0; tick(); tick(); chk("pre_lx", pc, 8'h8D);
    load_val = 8'h55; load = 1'b1;
    tick(); tick();
    exc_req = 4'b1000; tick();
    chk("lx_pc", pc, 8'h55);
    chk("lx_state", state, 2'b00);
    chk("lx_count", exc_count, 8'd3);
    exc_req = 4'h0; load = 1'b0;

    // Reset with a load pulse pending in the synchroniser
    tick(); tick(); load_val = 8'hAA; load = 1'b1;
    tick(); tick();
    #2; SYS_rst = 1'b0; #1;
    chk_reset_vals();
    load = 1'b0; SYS_rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_no_load", pc, 8'h03);

    // Exceptions at pcs 1..5
    SYS_rst = 1'b0; #1; SYS_rst = 1'b1;
    tick(); chk("tr_start", pc, 8'h01);
    for (int k = 1; k <= 5; k++) begin
      exc_req = 4'b0001; tick();
      chk("tr_epc", epc, k);
      exc_req = 4'h0; eret = 1'b1; tick(); eret = 1'b0;
      chk("tr_ret", pc, k + 1);
    end
    chk("tr_count", exc_count, 8'd5);
`ifdef PCSEQ_TRACE_EN
    for (int s = 0; s < 4; s++) begin
      trace_sel = 2'(s); #1;
      chk("trace_pc", trace_pc, 5 - s);
    end
`endif

    // Saturation: 295 more exceptions -> 300 total
    for (int i = 0; i < 295; i++) begin
      exc_req = 4'b0010; tick();
      exc_req = 4'h0; eret = 1'b1; tick(); eret = 1'b0;
    end
    chk("sat_255", exc_count, 8'd255);
    exc_req = 4'b0010; tick(); exc_req = 4'h0;
    chk("sat_hold", exc_count, 8'd255);
    chk("sat_state", state, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
